// File: rtl/c2h_burst_tx_if.sv
// C2H AXI-Stream data path plus CMPT completion stream between the burst
// transmitter and the QDMA ports.
interface c2h_burst_tx_if #(
  parameter int DATA_WIDTH = 256,
  parameter int QID_WIDTH  = 11
);
  logic [DATA_WIDTH-1:0] c2h_tdata;
  logic                  c2h_tvalid;
  logic                  c2h_tlast;
  logic                  c2h_tready;
  logic [15:0]           c2h_ctrl_len;
  logic [QID_WIDTH-1:0]  c2h_ctrl_qid;
  logic                  c2h_ctrl_has_cmpt;
  logic [5:0]            c2h_mty;
  logic [511:0]          cmpt_tdata;
  logic [1:0]            cmpt_size;
  logic                  cmpt_tvalid;
  logic [QID_WIDTH-1:0]  cmpt_ctrl_qid;
  logic                  cmpt_tready;

  modport master (
    output c2h_tdata, c2h_tvalid, c2h_tlast, c2h_ctrl_len, c2h_ctrl_qid,
           c2h_ctrl_has_cmpt, c2h_mty,
    output cmpt_tdata, cmpt_size, cmpt_tvalid, cmpt_ctrl_qid,
    input  c2h_tready, cmpt_tready
  );

  modport slave (
    input  c2h_tdata, c2h_tvalid, c2h_tlast, c2h_ctrl_len, c2h_ctrl_qid,
           c2h_ctrl_has_cmpt, c2h_mty,
    input  cmpt_tdata, cmpt_size, cmpt_tvalid, cmpt_ctrl_qid,
    output c2h_tready, cmpt_tready
  );
endinterface

// File: rtl/c2h_burst_tx.sv
// Snapshots the dut2vip bus on a capture strobe and sends it as one C2H
// packet of WORDS_NUM beats, optionally followed by a CMPT entry.
module c2h_burst_tx #(
  parameter int DATA_WIDTH = 256,
  parameter int QID_WIDTH  = 11,
  parameter int WORDS_NUM  = 16,
  parameter int CMPT_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            capture,
  input  logic [DATA_WIDTH*WORDS_NUM-1:0] dut2vip,
  input  logic [QID_WIDTH-1:0]            cfg_qid,
  output logic                            busy,
  output logic                            capture_drop,
  output logic [31:0]                     pkt_cnt,
  c2h_burst_tx_if.master                  tx
);

  localparam int IDX_W = (WORDS_NUM > 1) ? $clog2(WORDS_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_NUM - 1);
  localparam logic [15:0] PKT_LEN = 16'(WORDS_NUM * DATA_WIDTH / 8);
  localparam logic HAS_CMPT = (CMPT_EN != 0);

  typedef enum logic [1:0] {IDLE, SEND, CMPT} state_t;

  state_t state, state_nxt;

  logic [WORDS_NUM-1:0][DATA_WIDTH-1:0] buf_q;
  logic [QID_WIDTH-1:0]                 qid_q;
  logic [IDX_W-1:0]                     idx_q;
  logic                                 accept;
  logic                                 beat_done;
  logic                                 cmpt_done;
  logic                                 last_beat;

  assign last_beat = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beat_done = 1'b0;
    cmpt_done = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx.c2h_tready) begin
          beat_done = 1'b1;
          if (last_beat) state_nxt = HAS_CMPT ? CMPT : IDLE;
        end
      end
      CMPT: begin
        if (tx.cmpt_tready) begin
          cmpt_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet count advances on whichever handshake closes the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q        <= '0;
      qid_q        <= '0;
      idx_q        <= '0;
      pkt_cnt      <= '0;
      capture_drop <= 1'b0;
    end else begin
      capture_drop <= capture && (state != IDLE);
      if (accept) begin
        buf_q <= dut2vip;
        qid_q <= cfg_qid;
        idx_q <= '0;
      end else if (beat_done && !last_beat) begin
        idx_q <= idx_q + 1'b1;
      end
      if (cmpt_done || (!HAS_CMPT && beat_done && last_beat))
        pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  always_comb begin
    busy                 = (state != IDLE);
    tx.c2h_tvalid        = (state == SEND);
    tx.c2h_tlast         = (state == SEND) && last_beat;
    tx.c2h_tdata         = buf_q[idx_q];
    tx.c2h_ctrl_len      = PKT_LEN;
    tx.c2h_ctrl_qid      = qid_q;
    tx.c2h_ctrl_has_cmpt = HAS_CMPT;
    tx.c2h_mty           = '0;
    tx.cmpt_size         = 2'b00;
    tx.cmpt_tvalid       = (state == CMPT);
    tx.cmpt_ctrl_qid     = qid_q;
    tx.cmpt_tdata        = '0;
    tx.cmpt_tdata[19:4]  = PKT_LEN;
    tx.cmpt_tdata[51:20] = pkt_cnt;
  end

endmodule

// File: tb/tb_c2h_burst_tx.sv
// Bench for c2h_burst_tx: default-parameter instance checked every cycle
// against a packet-level model, plus a WORDS_NUM=1 / CMPT_EN=0 instance.
module tb_c2h_burst_tx;

  localparam int D   = 256;
  localparam int Q   = 11;
  localparam int W   = 16;
  localparam int LEN = W * D / 8;

  logic clk;
  logic rst;

  logic           cap_a, cap_b;
  logic [W*D-1:0] d2v_a;
  logic [D-1:0]   d2v_b;
  logic [Q-1:0]   qid_a, qid_b;
  logic           busy_a, busy_b, drop_a, drop_b;
  logic [31:0]    cnt_a, cnt_b;

  c2h_burst_tx_if #(.DATA_WIDTH(D), .QID_WIDTH(Q)) ifa ();
  c2h_burst_tx_if #(.DATA_WIDTH(D), .QID_WIDTH(Q)) ifb ();

  c2h_burst_tx #(.DATA_WIDTH(D), .QID_WIDTH(Q), .WORDS_NUM(W), .CMPT_EN(1)) dut_a (
    .clk(clk), .rst(rst), .capture(cap_a), .dut2vip(d2v_a), .cfg_qid(qid_a),
    .busy(busy_a), .capture_drop(drop_a), .pkt_cnt(cnt_a), .tx(ifa.master)
  );

  c2h_burst_tx #(.DATA_WIDTH(D), .QID_WIDTH(Q), .WORDS_NUM(1), .CMPT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .capture(cap_b), .dut2vip(d2v_b), .cfg_qid(qid_b),
    .busy(busy_b), .capture_drop(drop_b), .pkt_cnt(cnt_b), .tx(ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*D-1:0] pat(input logic [31:0] base);
    logic [W*D-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++)
      for (int j = 0; j < D / 32; j++)
        r[k*D + j*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  // Packet-level model of instance A
  logic [W*D-1:0] m_buf;
  logic [Q-1:0]   m_qid;
  int unsigned    m_beat;
  bit             m_active, m_cmpt, m_drop, m_was_busy;
  logic [31:0]    m_seq;
  logic [511:0]   m_cmpt_exp;

  initial begin
    m_buf = '0; m_qid = '0; m_beat = 0; m_active = 0; m_cmpt = 0;
    m_drop = 0; m_seq = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_cmpt = 0; m_drop = 0; m_seq = '0; m_beat = 0;
    end else begin
      m_was_busy = m_active || m_cmpt;
      m_drop = cap_a && m_was_busy;
      if (m_active && ifa.c2h_tready) begin
        if (m_beat == W - 1) begin
          m_active = 0;
          m_cmpt   = 1;
        end else begin
          m_beat++;
        end
      end else if (m_cmpt && ifa.cmpt_tready) begin
        m_cmpt = 0;
        m_seq  = m_seq + 32'd1;
      end
      if (cap_a && !m_was_busy) begin
        m_buf = d2v_a; m_qid = qid_a; m_beat = 0; m_active = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy_a, m_active || m_cmpt);
      chk("tvalid", ifa.c2h_tvalid, m_active);
      chk("cmpt_tvalid", ifa.cmpt_tvalid, m_cmpt);
      chk("capture_drop", drop_a, m_drop);
      chk("pkt_cnt", cnt_a, m_seq);
      chk("mty", ifa.c2h_mty, 0);
      chk("cmpt_size", ifa.cmpt_size, 0);
      chk("has_cmpt", ifa.c2h_ctrl_has_cmpt, 1);
      if (m_active) begin
        chk("tdata", ifa.c2h_tdata, m_buf[m_beat*D +: D]);
        chk("tlast", ifa.c2h_tlast, m_beat == W - 1);
        chk("ctrl_qid", ifa.c2h_ctrl_qid, m_qid);
        chk("ctrl_len", ifa.c2h_ctrl_len, LEN);
      end else begin
        chk("tlast_idle", ifa.c2h_tlast, 0);
      end
      if (m_cmpt) begin
        m_cmpt_exp = (512'(m_seq) << 20) | (512'(LEN) << 4);
        chk("cmpt_tdata", ifa.cmpt_tdata, m_cmpt_exp);
        chk("cmpt_qid", ifa.cmpt_ctrl_qid, m_qid);
      end
    end
  end

  // Observed-traffic tallies used by the literal expectations
  int           beats_a = 0, pkts_a = 0, drops_a = 0, b_cmpt_seen = 0;
  logic [D-1:0] last_data_a = '0;
  logic [511:0] last_cmpt = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.c2h_tvalid && ifa.c2h_tready) begin
        beats_a++;
        if (ifa.c2h_tlast) begin
          pkts_a++;
          last_data_a = ifa.c2h_tdata;
        end
      end
      if (ifa.cmpt_tvalid && ifa.cmpt_tready) last_cmpt = ifa.cmpt_tdata;
      if (drop_a) drops_a++;
      if (ifb.cmpt_tvalid) b_cmpt_seen++;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_a && n < 200) begin
      step();
      n++;
    end
    chk(name, busy_a, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    beats_a = 0; pkts_a = 0; drops_a = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cap_a = 0; d2v_a = '0; qid_a = '0; ifa.c2h_tready = 1; ifa.cmpt_tready = 1;
    cap_b = 0; d2v_b = '0; qid_b = '0; ifb.c2h_tready = 1; ifb.cmpt_tready = 1;
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_busy", busy_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_tvalid", ifa.c2h_tvalid, 0);
    chk("rst_cmpt_tvalid", ifa.cmpt_tvalid, 0);
    chk("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    step();

    // Basic packet
    d2v_a = pat(32'hA000_0000); qid_a = 5; cap_a = 1; step(); cap_a = 0;
    chk("basic_lat1", ifa.c2h_tvalid, 1);
    chk("basic_word0", ifa.c2h_tdata, {8{32'hA000_0000}});
    chk("basic_len", ifa.c2h_ctrl_len, 512);
    chk("basic_qid", ifa.c2h_ctrl_qid, 5);
    wait_idle("basic_idle");
    chk("basic_beats", beats_a, 16);
    chk("basic_last_word", last_data_a, {8{32'hA000_000F}});
    chk("basic_cmpt_len", last_cmpt[19:4], 512);
    chk("basic_cmpt_seq", last_cmpt[51:20], 0);
    chk("basic_cnt", cnt_a, 1);

    // Backpressure on both streams
    do_reset();
    d2v_a = pat(32'h5500_0000); qid_a = 11'h123; ifa.cmpt_tready = 0;
    cap_a = 1; step(); cap_a = 0;
    n = 0;
    while (!ifa.cmpt_tvalid && n < 200) begin
      ifa.c2h_tready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    ifa.c2h_tready = 1;
    chk("bp_cmpt_reached", ifa.cmpt_tvalid, 1);
    chk("bp_beats", beats_a, 16);
    chk("bp_last_word", last_data_a, {8{32'h5500_000F}});
    repeat (5) step();
    chk("bp_cmpt_held", ifa.cmpt_tvalid, 1);
    ifa.cmpt_tready = 1;
    wait_idle("bp_idle");
    chk("bp_cnt", cnt_a, 1);

    // Capture while busy
    do_reset();
    d2v_a = pat(32'hB000_0000); qid_a = 9; cap_a = 1; step(); cap_a = 0;
    repeat (3) step();
    chk("busy_word3", ifa.c2h_tdata, {8{32'hB000_0003}});
    d2v_a = pat(32'hC000_0000); qid_a = 2; cap_a = 1; step(); cap_a = 0;
    chk("busy_drop_pulse", drop_a, 1);
    step();
    chk("busy_drop_once", drop_a, 0);
    wait_idle("busy_idle");
    chk("busy_drops", drops_a, 1);
    chk("busy_pkts", pkts_a, 1);
    chk("busy_beats", beats_a, 16);
    chk("busy_last_word", last_data_a, {8{32'hB000_000F}});
    chk("busy_cnt", cnt_a, 1);

    // Back-to-back, captures 18 cycles apart
    do_reset();
    d2v_a = pat(32'hD000_0000); qid_a = 1; cap_a = 1; step(); cap_a = 0;
    repeat (17) step();
    d2v_a = pat(32'hE000_0000); qid_a = 4; cap_a = 1; step(); cap_a = 0;
    chk("b2b_lat1", ifa.c2h_tvalid, 1);
    chk("b2b_word0", ifa.c2h_tdata, {8{32'hE000_0000}});
    chk("b2b_qid", ifa.c2h_ctrl_qid, 4);
    wait_idle("b2b_idle");
    chk("b2b_drops", drops_a, 0);
    chk("b2b_pkts", pkts_a, 2);
    chk("b2b_cmpt_seq", last_cmpt[51:20], 1);
    chk("b2b_cnt", cnt_a, 2);

    // Reset mid-packet
    do_reset();
    d2v_a = pat(32'h1200_0000); qid_a = 6; cap_a = 1; step(); cap_a = 0;
    repeat (7) step();
    chk("mid_word7", ifa.c2h_tdata, {8{32'h1200_0007}});
    rst = 1; step();
    chk("mid_tvalid", ifa.c2h_tvalid, 0);
    chk("mid_busy", busy_a, 0);
    chk("mid_cnt", cnt_a, 0);
    rst = 0; pkts_a = 0; beats_a = 0;
    d2v_a = pat(32'h3400_0000); qid_a = 7; cap_a = 1; step(); cap_a = 0;
    chk("mid_new_word0", ifa.c2h_tdata, {8{32'h3400_0000}});
    wait_idle("mid_idle");
    chk("mid_beats", beats_a, 16);
    chk("mid_pkts", pkts_a, 1);
    chk("mid_cmpt_seq", last_cmpt[51:20], 0);
    chk("mid_cnt", cnt_a, 1);

    // Single-beat instance without completions
    d2v_b = {8{32'h0B0B_0001}}; qid_b = 3; cap_b = 1; step(); cap_b = 0;
    chk("b_tvalid", ifb.c2h_tvalid, 1);
    chk("b_tlast", ifb.c2h_tlast, 1);
    chk("b_tdata", ifb.c2h_tdata, {8{32'h0B0B_0001}});
    chk("b_has_cmpt", ifb.c2h_ctrl_has_cmpt, 0);
    chk("b_len", ifb.c2h_ctrl_len, 32);
    chk("b_qid", ifb.c2h_ctrl_qid, 3);
    chk("b_busy", busy_b, 1);
    chk("b_cnt_before", cnt_b, 0);
    step();
    chk("b_cnt_after", cnt_b, 1);
    chk("b_busy_after", busy_b, 0);
    chk("b_tvalid_after", ifb.c2h_tvalid, 0);
    ifb.c2h_tready = 0;
    d2v_b = {8{32'h0B0B_0002}}; cap_b = 1; step(); cap_b = 0;
    d2v_b = '0;
    step();
    chk("b_hold_tvalid", ifb.c2h_tvalid, 1);
    chk("b_hold_tdata", ifb.c2h_tdata, {8{32'h0B0B_0002}});
    chk("b_hold_cnt", cnt_b, 1);
    ifb.c2h_tready = 1;
    step();
    chk("b_cnt_2", cnt_b, 2);
    chk("b_busy_2", busy_b, 0);
    chk("b_cmpt_never", b_cmpt_seen, 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c2h_burst_tx.md
Name: c2h_burst_tx

Overview:
- Downstream consumer of the gated DUT output bus (dut2vip) in the QDMA application.
- On a capture pulse it snapshots the full DUT2VIP-wide bus and serializes it as one C2H AXI-Stream packet of WORDS_NUM beats.
- It then issues one completion (CMPT) entry carrying the packet length and a sequence number.
- It sits between the capture-strobe pipeline and the QDMA C2H/CMPT stream ports.

Parameters:
- DATA_WIDTH, 256, C2H beat width in bits; must be a multiple of 8.
- QID_WIDTH, 11, queue ID width.
- WORDS_NUM, 16, beats per packet; dut2vip width = DATA_WIDTH*WORDS_NUM; range 1..255.
- CMPT_EN, 1, 1 = emit a CMPT entry after every packet; 0 = no CMPT.

Ports:
- clk  in  1  single clock; ungated application clock.
- rst  in  1  reset; synchronous, active-high.
- capture  in  1  single-cycle strobe: snapshot dut2vip and send it.
- dut2vip  in  DATA_WIDTH*WORDS_NUM  DUT output bus; sampled only when a capture is accepted.
- cfg_qid  in  QID_WIDTH  destination queue; sampled when a capture is accepted.
- busy  out  1  high whenever state != IDLE.
- capture_drop  out  1  one-cycle pulse reporting a capture rejected because the block was busy.
- pkt_cnt  out  32  number of completed packets.
- c2h_tdata  out  DATA_WIDTH  beat data.
- c2h_tvalid  out  1  beat valid.
- c2h_tlast  out  1  last beat of the packet.
- c2h_tready  in  1  downstream ready.
- c2h_ctrl_len  out  16  packet length in bytes.
- c2h_ctrl_qid  out  QID_WIDTH  latched qid.
- c2h_ctrl_has_cmpt  out  1  equals CMPT_EN.
- c2h_mty  out  6  empty bytes in the last beat; always 0.
- cmpt_tdata  out  512  completion entry.
- cmpt_size  out  2  completion size; constant 2'b00 (8 B).
- cmpt_tvalid  out  1  completion valid.
- cmpt_ctrl_qid  out  QID_WIDTH  latched qid.
- cmpt_tready  in  1  completion ready.

Behaviour:
- Reset values: state IDLE; busy, capture_drop, c2h_tvalid, c2h_tlast and cmpt_tvalid = 0; pkt_cnt = 0; beat index = 0; data buffer and latched qid = 0.
- Reset mid-packet or mid-CMPT: the packet is abandoned. tvalid and cmpt_tvalid are 0 from the first edge with rst high, and no partial tlast is produced.
- Constants:
  - c2h_ctrl_len = WORDS_NUM*DATA_WIDTH/8 (512 for the defaults); computed at elaboration; must fit in 16 bits.
  - c2h_mty = 0.
- FSM states: IDLE, SEND, CMPT.
- IDLE:
  - capture=1 latches dut2vip into the buffer and cfg_qid into the qid register, and clears the beat index to 0.
  - Next state is SEND, so c2h_tvalid is high in the cycle after capture (latency 1).
- SEND:
  - c2h_tdata = buffer[(idx+1)*DATA_WIDTH-1 : idx*DATA_WIDTH]; word 0 (the LSBs) is sent first.
  - c2h_tlast = (idx == WORDS_NUM-1).
  - A beat completes only when c2h_tvalid & c2h_tready. On completion idx increments; on the last beat the FSM goes to CMPT (CMPT_EN=1) or to IDLE (CMPT_EN=0).
  - While tvalid=1 and tready=0, tdata, tlast and the ctrl_* outputs are held stable.
  - With tready held high, beats go out one per cycle with no bubbles.
- CMPT:
  - cmpt_tvalid = 1; cmpt_ctrl_qid = latched qid.
  - cmpt_tdata: [3:0] = 0 (reserved); [19:4] = c2h_ctrl_len; [51:20] = pkt_cnt (value before increment); remaining bits 0.
  - Outputs are held until cmpt_tready. On the handshake: state goes to IDLE and pkt_cnt increments.
- pkt_cnt increment:
  - CMPT_EN=1: on the CMPT handshake.
  - CMPT_EN=0: on the last-beat handshake.
  - Wraps from 0xFFFFFFFF to 0.
- Capture while busy (any state other than IDLE, including the cycle of the final handshake):
  - The capture is ignored; buffer, qid and state are unchanged.
  - capture_drop pulses high in the next cycle for exactly one cycle per dropped capture.
- Back-to-back operation: a capture in the first IDLE cycle after completion is accepted. Minimum capture-to-capture spacing with no backpressure = WORDS_NUM + 2 cycles (CMPT_EN=1) or WORDS_NUM + 1 cycles (CMPT_EN=0).
- dut2vip may change freely after the capture cycle; the transmitted data is always the snapshot taken at capture.
- WORDS_NUM = 1: the single beat has tlast=1 in the first SEND cycle.

Test Plan:
- Basic packet (defaults): dut2vip word k = {8{32'hA000_0000+k}}, cfg_qid=5, capture pulse, tready=1.
  - Expect tvalid starting 1 cycle later; 16 consecutive beats, words 0..15 in order; tlast only on beat 15; ctrl_len=512; ctrl_qid=5.
  - Then one cmpt_tvalid cycle with cmpt_tdata[19:4]=512 and [51:20]=0; pkt_cnt=1 afterwards.
- Backpressure: tready toggles 1,0,0,1 repeating during SEND.
  - Expect tdata, tlast and ctrl_* stable whenever tready=0; exactly 16 accepted beats with no duplicated or skipped words.
  - Hold cmpt_tready=0 for 5 cycles: cmpt_tvalid stays high, and cmpt_tdata is stable until the handshake.
- Capture while busy: second capture at beat 3, with dut2vip changed in the same cycle.
  - Expect a single capture_drop pulse on the next cycle; packet data unchanged; only one packet sent; pkt_cnt=1.
- Back-to-back with tready=1: two captures spaced exactly 18 cycles apart.
  - Expect both packets accepted with no capture_drop; second CMPT sequence field = 1; pkt_cnt=2.
- Reset mid-packet: assert rst at beat 7.
  - Expect tvalid=0 at the next edge, pkt_cnt=0 and busy=0.
  - A subsequent capture produces a full 16-beat packet starting from word 0, with CMPT sequence field = 0.
- CMPT_EN=0, WORDS_NUM=1: capture pulse.
  - Expect a single beat with tlast=1, ctrl_has_cmpt=0 and cmpt_tvalid never asserted.
  - pkt_cnt increments on the beat handshake, and busy drops on the following cycle.
